dff_pin_exerciser: RTL and testbench
====================================

Name: dff_pin_exerciser

Overview:
- Synchronous stimulus/check engine that drives the pin interface of a gate-level D flip-flop under test (d, ck, pr, clr in; q, nq out).
- Runs a fixed-length vector sequence (clear, preset, directed captures, then pseudo-random) and compares q/nq against an internal reference bit.
- Reports pass/fail, an error count and the index of the first failing vector.
- Sits on the test side of flat or nested NAND-built flip-flops; the DUT clock is a generated pin, not the system clock.

Parameters:
- NUM_VECTORS, 16, total vectors per run; legal minimum 4.
- SETTLE_CYCLES, 2, system cycles each drive phase is held, giving gate-level loops time to settle; legal minimum 1.
- LFSR_SEED, 8'hA5, non-zero seed for the random vectors.

Ports:
- ck  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; starts a run from IDLE.
- dut_d  output  1  data pin to DUT.
- dut_ck  output  1  generated clock pin to DUT.
- dut_pr_n  output  1  preset pin to DUT, active-low.
- dut_clr_n  output  1  clear pin to DUT, active-low.
- dut_q  input  1  DUT q.
- dut_nq  input  1  DUT nq.
- busy  output  1  high while a run is in progress.
- done  output  1  level; high after a run completes until the next accepted start or rst.
- fail  output  1  sticky; set on any mismatch in the current run.
- err_cnt  output  8  number of mismatching vectors, saturates at 255.
- first_fail_idx  output  8  index of the first failing vector; valid when fail=1.

Behaviour:
- Reset (rst=1 at a ck edge): state IDLE. busy=0, done=0, fail=0, err_cnt=0, first_fail_idx=0, dut_d=0, dut_ck=0, dut_pr_n=1, dut_clr_n=1. LFSR is reloaded to LFSR_SEED and the vector index is cleared. Reset mid-run aborts the run immediately with the same values.
- Accepting a run: start=1 in IDLE or DONE moves to APPLY for vector 0 on the next cycle. That cycle clears done, fail, err_cnt and first_fail_idx, and sets busy=1. start while busy is ignored.
- States: IDLE -> APPLY -> EDGE -> RELEASE -> CHECK -> (APPLY for the next vector | DONE).
  - APPLY, EDGE and RELEASE each last exactly SETTLE_CYCLES cycles. CHECK lasts 1 cycle.
  - One vector therefore takes 3*SETTLE_CYCLES+1 cycles.
- Pin drive per phase:
  - APPLY: dut_d, dut_pr_n and dut_clr_n take the vector values; dut_ck=0.
  - EDGE: dut_ck=1; other pins held.
  - RELEASE: dut_ck=0; other pins held.
  - CHECK: pins held.
  - The next APPLY returns pr_n and clr_n to the new vector values. Pins change only at phase boundaries.
- Vector schedule:
  - Vector 0: clr_n=0, pr_n=1, d=1. Expected 0.
  - Vector 1: pr_n=0, clr_n=1, d=0. Expected 1.
  - Vector 2: capture with d=0. Expected 0.
  - Vector 3: capture with d=1. Expected 1.
  - Vectors 4 and up use the LFSR value L:
    - d = L[0].
    - L[3:1]=000: clear vector, expected 0.
    - L[3:1]=111: preset vector, expected 1.
    - Otherwise: capture vector, expected d.
  - pr_n and clr_n are never both low.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances once per vector on leaving CHECK, starting from LFSR_SEED at vector 4.
- Check: in CHECK, the vector fails if dut_q != expected or dut_nq != ~expected.
  - On a fail: err_cnt increments (saturating), fail is set.
  - On the first fail of a run: first_fail_idx is loaded with the vector index.
  - X/Z on dut_q or dut_nq counts as a mismatch.
- Completion: after CHECK of vector NUM_VECTORS-1, go to DONE. In that cycle busy=0 and done=1. DONE behaves like IDLE for start.
- Vector index width: 8 bits; NUM_VECTORS ≤ 256.

Test Plan:
- Ideal behavioural DFF model (async active-low pr/clr, posedge capture), defaults, one start pulse -> busy for 16*7=112 cycles; done=1 and busy=0 on cycle 113 after start; fail=0; err_cnt=0.
- DUT with q stuck at 0 (nq=~q) -> vector 1 fails first; first_fail_idx=1; vector 3 fails; err_cnt equals the count of expected-1 vectors (≥2); fail=1.
- DUT with nq tied equal to q -> every vector fails; err_cnt=16; first_fail_idx=0.
- rst asserted for 1 cycle at cycle 30 of a run -> next cycle: all outputs at reset values, dut_pr_n=1, dut_clr_n=1; a new start replays vector 0 identically.
- start pulsed again at cycle 10 of a run -> ignored; run completes at cycle 113 with unchanged results.
- SETTLE_CYCLES=1, NUM_VECTORS=4 with the ideal DUT -> each vector is 4 cycles; dut_ck high exactly 1 cycle per vector; done at cycle 17; fail=0.

Source files
------------

// File: rtl/dff_pin_exerciser.sv
// Stimulus/check engine for a gate-level D flip-flop: drives d/ck/pr_n/clr_n pins
// through a fixed vector run and scores q/nq against a reference bit.
`timescale 1ns/1ps
module dff_pin_exerciser #(
  parameter int         NUM_VECTORS   = 16,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  output logic       dut_d,
  output logic       dut_ck,
  output logic       dut_pr_n,
  output logic       dut_clr_n,
  input  logic       dut_q,
  input  logic       dut_nq,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] err_cnt,
  output logic [7:0] first_fail_idx
);

  localparam int         CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_EDGE, S_RELEASE, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          d_q, d_d, ck_q, ck_d, prn_q, prn_d, clrn_q, clrn_d;
  logic          exp_q, exp_d;
  logic          fail_q, fail_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    ffi_q, ffi_d;
  logic          load_vec, phase_end, mismatch;
  logic [3:0]    vec;

  // Vector packed as {d, pr_n, clr_n, expected}; pr_n and clr_n are never both low.
  function automatic logic [3:0] vector_of(input logic [7:0] idx, input logic [7:0] l);
    logic [3:0] v;
    if (idx == 8'd0)      v = 4'b1_1_0_0;
    else if (idx == 8'd1) v = 4'b0_0_1_1;
    else if (idx == 8'd2) v = 4'b0_1_1_0;
    else if (idx == 8'd3) v = 4'b1_1_1_1;
    else if (l[3:1] == 3'b000) v = {l[0], 1'b1, 1'b0, 1'b0};
    else if (l[3:1] == 3'b111) v = {l[0], 1'b0, 1'b1, 1'b1};
    else                       v = {l[0], 1'b1, 1'b1, l[0]};
    return v;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign phase_end = (cnt_q == PHASE_LAST);
  // Four-state compare so an X or Z on either DUT output scores as a failure.
  assign mismatch  = !((dut_q === exp_q) && (dut_nq === !exp_q));

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    d_d      = d_q;
    ck_d     = ck_q;
    prn_d    = prn_q;
    clrn_d   = clrn_q;
    exp_d    = exp_q;
    fail_d   = fail_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    load_vec = 1'b0;
    vec      = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          idx_d    = '0;
          lfsr_d   = LFSR_SEED;
          fail_d   = 1'b0;
          err_d    = '0;
          ffi_d    = '0;
          load_vec = 1'b1;
        end
      end
      S_APPLY: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_EDGE;
          cnt_d   = '0;
          ck_d    = 1'b1;
        end
      end
      S_EDGE: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          ck_d    = 1'b0;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          fail_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!fail_q) ffi_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_APPLY;
          idx_d    = idx_q + 8'd1;
          if (idx_q >= 8'd4) lfsr_d = lfsr_step(lfsr_q);
          load_vec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are loaded from the upcoming vector so they are stable for the whole APPLY phase.
    if (load_vec) begin
      vec    = vector_of(idx_d, lfsr_d);
      d_d    = vec[3];
      prn_d  = vec[2];
      clrn_d = vec[1];
      exp_d  = vec[0];
      ck_d   = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      d_q     <= 1'b0;
      ck_q    <= 1'b0;
      prn_q   <= 1'b1;
      clrn_q  <= 1'b1;
      exp_q   <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      d_q     <= d_d;
      ck_q    <= ck_d;
      prn_q   <= prn_d;
      clrn_q  <= clrn_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
    end
  end

  assign dut_d          = d_q;
  assign dut_ck         = ck_q;
  assign dut_pr_n       = prn_q;
  assign dut_clr_n      = clrn_q;
  assign busy           = (state_q == S_APPLY) || (state_q == S_EDGE) ||
                          (state_q == S_RELEASE) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign fail           = fail_q;
  assign err_cnt        = err_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_dff_pin_exerciser.sv
// Bench for dff_pin_exerciser: behavioural DFF with selectable faults, a vector-table
// model built from the schedule rules, and per-cycle pin/result checks.
`timescale 1ns/1ps
module tb_dff_pin_exerciser;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       rst, start0, start1;
  logic       dd0, dck0, prn0, clrn0, q0, nq0, busy0, done0, fail0;
  logic [7:0] err0, ffi0;
  logic       dd1, dck1, prn1, clrn1, q1, nq1, busy1, done1, fail1;
  logic [7:0] err1, ffi1;
  logic       ff0 = 1'b0;
  logic       ff1 = 1'b0;
  int         mode0;
  int         checks   = 0;
  int         failures = 0;

  logic vd[256], vpr[256], vclr[256], vexp[256];

  dff_pin_exerciser u_dut0 (
    .ck(ck), .rst(rst), .start(start0),
    .dut_d(dd0), .dut_ck(dck0), .dut_pr_n(prn0), .dut_clr_n(clrn0),
    .dut_q(q0), .dut_nq(nq0),
    .busy(busy0), .done(done0), .fail(fail0),
    .err_cnt(err0), .first_fail_idx(ffi0)
  );

  dff_pin_exerciser #(.NUM_VECTORS(4), .SETTLE_CYCLES(1)) u_dut1 (
    .ck(ck), .rst(rst), .start(start1),
    .dut_d(dd1), .dut_ck(dck1), .dut_pr_n(prn1), .dut_clr_n(clrn1),
    .dut_q(q1), .dut_nq(nq1),
    .busy(busy1), .done(done1), .fail(fail1),
    .err_cnt(err1), .first_fail_idx(ffi1)
  );

  // Ideal flip-flops under test; mode0 plants q-stuck-at-0 (1) or nq tied to q (2).
  always @(posedge dck0 or negedge prn0 or negedge clrn0)
    if (!clrn0) ff0 <= 1'b0;
    else if (!prn0) ff0 <= 1'b1;
    else ff0 <= dd0;
  assign q0  = (mode0 == 1) ? 1'b0 : ff0;
  assign nq0 = (mode0 == 2) ? q0 : ~q0;

  always @(posedge dck1 or negedge prn1 or negedge clrn1)
    if (!clrn1) ff1 <= 1'b0;
    else if (!prn1) ff1 <= 1'b1;
    else ff1 <= dd1;
  assign q1  = ff1;
  assign nq1 = ~ff1;

  function automatic void build_vectors(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) begin
      if (i < 4) begin
        vd[i]   = (i == 0) || (i == 3);
        vpr[i]  = (i != 1);
        vclr[i] = (i != 0);
        vexp[i] = (i == 1) || (i == 3);
      end else begin
        vd[i]   = l[0];
        vclr[i] = (l[3:1] != 3'd0);
        vpr[i]  = (l[3:1] != 3'd7);
        vexp[i] = (l[3:1] == 3'd0) ? 1'b0 : (l[3:1] == 3'd7) ? 1'b1 : l[0];
        l = {l[6:0], ^(l & 8'b1011_1000)};
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge ck);
    checks++;
    if ({busy0, done0, fail0, dd0, dck0, prn0, clrn0} !== 7'b0000011) begin
      failures++;
      $display("[TB] FAIL reset_pins0 got=%b want=0000011", {busy0, done0, fail0, dd0, dck0, prn0, clrn0});
    end
    checks++;
    if ({err0, ffi0} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_cnt0 got err=%0d ffi=%0d want 0/0", err0, ffi0);
    end
    checks++;
    if ({busy1, done1, fail1, dd1, dck1, prn1, clrn1, err1, ffi1} !== {7'b0000011, 16'h0}) begin
      failures++;
      $display("[TB] FAIL reset_dut1 got=%b", {busy1, done1, fail1, dd1, dck1, prn1, clrn1, err1, ffi1});
    end
    rst = 1'b0;
  endtask

  // One full run on dut0 starting at the current negedge; optional abort or stray start.
  task automatic run_check(input int mode, input int abort_at, input int restart_at, input string tag);
    int v, p, exp_err;
    logic exp_fail;
    logic [7:0] exp_ffi;
    logic [5:0] want, got;
    mode0 = mode;
    start0 = 1'b1;
    @(negedge ck);
    for (int c = 1; c <= 112; c++) begin
      v = (c - 1) / 7;
      p = (c - 1) % 7;
      want = {1'b1, 1'b0, (p >= 2 && p < 4), vd[v], vpr[v], vclr[v]};
      got  = {busy0, done0, dck0, dd0, prn0, clrn0};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL %s_pins cycle=%0d got=%b want=%b", tag, c, got, want);
      end
      if (c == 1) begin
        checks++;
        if ({fail0, err0, ffi0} !== 17'h0) begin
          failures++;
          $display("[TB] FAIL %s_cleared got fail=%b err=%0d ffi=%0d want 0", tag, fail0, err0, ffi0);
        end
      end
      start0 = (c == restart_at);
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        checks++;
        if ({busy0, done0, fail0, dd0, dck0, prn0, clrn0, err0, ffi0} !== {7'b0000011, 16'h0}) begin
          failures++;
          $display("[TB] FAIL %s_abort got=%b want all reset values", tag,
                   {busy0, done0, fail0, dd0, dck0, prn0, clrn0, err0, ffi0});
        end
        return;
      end
      @(negedge ck);
    end
    start0 = 1'b0;
    exp_err = 0; exp_fail = 1'b0; exp_ffi = 8'd0;
    for (int i = 0; i < 16; i++) begin
      if ((mode == 2) || (mode == 1 && vexp[i])) begin
        if (!exp_fail) exp_ffi = 8'(i);
        exp_fail = 1'b1;
        exp_err++;
      end
    end
    checks++;
    if ({busy0, done0} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL %s_done got busy=%b done=%b want 0/1", tag, busy0, done0);
    end
    checks++;
    if (fail0 !== exp_fail || err0 !== 8'(exp_err)) begin
      failures++;
      $display("[TB] FAIL %s_result got fail=%b err=%0d want fail=%b err=%0d", tag, fail0, err0, exp_fail, exp_err);
    end
    if (exp_fail) begin
      checks++;
      if (ffi0 !== exp_ffi) begin
        failures++;
        $display("[TB] FAIL %s_first got=%0d want=%0d", tag, ffi0, exp_ffi);
      end
    end
  endtask

  task automatic test_ideal();         run_check(0, 0, 0, "ideal");     endtask
  task automatic test_stuck_q();       run_check(1, 0, 0, "stuckq");    endtask
  task automatic test_nq_eq_q();       run_check(2, 0, 0, "nqeqq");     endtask
  task automatic test_back_to_back();  run_check(0, 0, 0, "b2b");       endtask
  task automatic test_restart_ignored(); run_check(2, 0, 10, "restart"); endtask

  task automatic test_abort();
    run_check(1, 30, 0, "abort");
    run_check(0, 0, 0, "replay");
  endtask

  task automatic test_random_runs();
    int m, gap, rs;
    for (int k = 0; k < 4; k++) begin
      m   = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 4));
      rs  = int'($urandom_range(0, 112));
      repeat (gap) @(negedge ck);
      run_check(m, 0, rs, "random");
    end
  endtask

  task automatic test_short_config();
    int v, p;
    logic [5:0] want, got;
    start1 = 1'b1;
    @(negedge ck);
    start1 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      v = (c - 1) / 4;
      p = (c - 1) % 4;
      want = {1'b1, 1'b0, (p == 1), vd[v], vpr[v], vclr[v]};
      got  = {busy1, done1, dck1, dd1, prn1, clrn1};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL short_pins cycle=%0d got=%b want=%b", c, got, want);
      end
      @(negedge ck);
    end
    checks++;
    if ({busy1, done1, fail1, err1} !== {3'b010, 8'd0}) begin
      failures++;
      $display("[TB] FAIL short_done got busy=%b done=%b fail=%b err=%0d want 0/1/0/0", busy1, done1, fail1, err1);
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0;
    build_vectors(16);
    test_reset();
    @(negedge ck);
    test_ideal();
    test_stuck_q();
    test_nq_eq_q();
    test_back_to_back();
    test_abort();
    test_restart_ignored();
    test_random_runs();
    test_short_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
